// File: rtl/bin2bcd_4d_if.sv
// Request/result bundle between an upstream producer and the binary-to-BCD
// converter. The master supplies the binary value and the slave returns the
// packed BCD digits.
interface bin2bcd_4d_if #(
    parameter int BIN_W = 14
);
    logic [BIN_W-1:0] bin;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      bcd;
    logic             done;
    logic             ovf;

    modport master (
        output bin, in_valid,
        input  in_ready, bcd, done, ovf
    );

    modport slave (
        input  bin, in_valid,
        output in_ready, bcd, done, ovf
    );
endinterface

// File: rtl/bin2bcd_4d.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// The result register feeds the 4-digit display directly and is written
// only on the final shift, so the display never shows partial digits.
// Values above 9999 saturate to 9999 and set ovf.
module bin2bcd_4d #(
    parameter int BIN_W = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_4d_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0]  LAST    = 5'(BIN_W - 1);
    localparam logic [16:0] BCD_MAX = 17'd9999;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [15:0]      scratch_q, scratch_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             ovf_q, ovf_d;

    logic [15:0]      adj;
    logic [15:0]      scratch_sh;
    logic [16:0]      bin_ext;

    // Add-3 correction on every nibble >= 5, all four in parallel.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    // Top scratch bit is dropped; that only happens for saturated inputs.
    assign scratch_sh = {adj[14:0], shift_q[BIN_W-1]};
    assign bin_ext    = 17'(bus.bin);

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shift_d   = bus.bin;
                    scratch_d = 16'h0000;
                    pend_d    = (bin_ext > BCD_MAX);
                    cnt_d     = 5'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_sh;
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    bcd_d   = pend_q ? 16'h9999 : scratch_sh;
                    ovf_d   = pend_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= 16'h0000;
            cnt_q     <= 5'd0;
            pend_q    <= 1'b0;
            bcd_q     <= 16'h0000;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.bcd      = bcd_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_bin2bcd_4d.sv
// Bench for bin2bcd_4d: expected results are queued at each accept edge
// from a decimal-arithmetic model and compared when done pulses.
module tb_bin2bcd_4d;
    localparam int BIN_W = 14;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    bin2bcd_4d_if #(.BIN_W(BIN_W)) bus ();

    bin2bcd_4d #(.BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input int v, input int acc);
        exp_t e;
        e.acc = acc;
        if (v > 9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard push on every accept edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(int'(bus.bin), cyc + 1));
            acc_cnt <= acc_cnt + 1;
        end
    end

    always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic run_one(input int v, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
        bus.bin = BIN_W'(v);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int d0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.bin = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", bus.bcd); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        total++; if (bus.in_ready !== 1'b1 || done_cnt != d0 || exp_q.size() != 0) begin
            bad++; $display("FAIL idle_quiet ready=%b dones=%0d queued=%0d exp=1/0/0", bus.in_ready, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_single();
        int low, lat;
        bit got, held;
        logic [15:0] prev;
        exp_t e;
        prev = bus.bcd;
        bus.bin = BIN_W'(1234);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        low = 0; got = 1'b0; held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!bus.in_ready) low++;
            if (bus.done) begin got = 1'b1; break; end
            if (bus.bcd !== prev) held = 1'b0;
            @(negedge clk);
        end
        total++; if (!got) begin bad++; $display("FAIL single_done got=timeout exp=pulse"); end
        total++; if (!held) begin bad++; $display("FAIL single_hold bcd changed before done exp=%h", prev); end
        if (exp_q.size() == 0) begin
            total++; bad++; $display("FAIL single_sb got=empty exp=entry");
        end else begin
            e = exp_q.pop_front();
            lat = cyc - e.acc;
            total++; if (lat != 14) begin bad++; $display("FAIL single_latency got=%0d exp=14", lat); end
            total++; if (bus.bcd !== e.bcd || bus.ovf !== e.ovf) begin
                bad++; $display("FAIL single_result got=%h/%b exp=%h/%b", bus.bcd, bus.ovf, e.bcd, e.ovf);
            end
        end
        @(negedge clk);
        total++; if (bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL single_after done=%b ready=%b exp=0/1", bus.done, bus.in_ready);
        end
        total++; if (low != 15) begin bad++; $display("FAIL single_busy got=%0d exp=15", low); end
    endtask

    task automatic test_ranges();
        int vals[4] = '{9999, 10000, 16383, 0};
        bit ok;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_one(vals[i], ok);
            if (!ok || exp_q.size() == 0) begin
                total++; bad++; $display("FAIL range_%0d got=no_result exp=result", vals[i]);
            end else begin
                e = exp_q.pop_front();
                total++; if (bus.bcd !== e.bcd) begin bad++; $display("FAIL range_bcd_%0d got=%h exp=%h", vals[i], bus.bcd, e.bcd); end
                total++; if (bus.ovf !== e.ovf) begin bad++; $display("FAIL range_ovf_%0d got=%b exp=%b", vals[i], bus.ovf, e.ovf); end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        bit got, held;
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
        bus.bin = BIN_W'(42);
        bus.in_valid = 1'b1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        bus.bin = BIN_W'(7);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got || exp_q.size() == 0) begin
            total++; bad++; $display("FAIL b2b_first got=no_result exp=0042");
            bus.in_valid = 1'b0;
            return;
        end
        e1 = exp_q.pop_front();
        total++; if (bus.bcd !== e1.bcd || bus.bcd !== 16'h0042) begin
            bad++; $display("FAIL b2b_first got=%h exp=%h", bus.bcd, e1.bcd);
        end
        n = 0;
        while (exp_q.size() == 0 && n < 40) begin @(negedge clk); n++; end
        bus.in_valid = 1'b0;
        if (exp_q.size() == 0) begin
            total++; bad++; $display("FAIL b2b_second_accept got=none exp=accept");
            return;
        end
        total++; if (exp_q[0].acc - e1.acc != 16) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=16", exp_q[0].acc - e1.acc);
        end
        got = 1'b0; held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin got = 1'b1; break; end
            if (bus.bcd !== 16'h0042) held = 1'b0;
            @(negedge clk);
        end
        total++; if (!held) begin bad++; $display("FAIL b2b_hold bcd changed mid-conversion exp=0042"); end
        e2 = exp_q.pop_front();
        total++; if (!got || bus.bcd !== e2.bcd || e2.bcd !== 16'h0007) begin
            bad++; $display("FAIL b2b_second got=%h exp=%h", bus.bcd, e2.bcd);
        end
    endtask

    task automatic test_reset_mid();
        int d0, n;
        bit ok;
        exp_t e;
        n = 0;
        while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
        bus.bin = BIN_W'(5678);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL rstmid_bcd got=%h exp=0000", bus.bcd); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.in_ready); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_nodone got=%0d exp=0", done_cnt - d0); end
        run_one(321, ok);
        if (!ok || exp_q.size() == 0) begin
            total++; bad++; $display("FAIL rstmid_321 got=no_result exp=0321");
        end else begin
            e = exp_q.pop_front();
            total++; if (bus.bcd !== e.bcd || bus.ovf !== e.ovf) begin
                bad++; $display("FAIL rstmid_321 got=%h/%b exp=%h/%b", bus.bcd, bus.ovf, e.bcd, e.ovf);
            end
        end
    endtask

    task automatic test_sweep();
        int vals[$];
        int edge_vals[13] = '{1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 10001, 16382, 16383};
        for (int v = 0; v < 16384; v += 53) vals.push_back(v);
        foreach (edge_vals[k]) vals.push_back(edge_vals[k]);
        fork
            begin
                int a0, n;
                for (int i = 0; i < vals.size(); i++) begin
                    bus.bin = BIN_W'(vals[i]);
                    bus.in_valid = 1'b1;
                    a0 = acc_cnt;
                    n = 0;
                    do begin @(negedge clk); n++; end while (acc_cnt == a0 && n < 40);
                end
                bus.in_valid = 1'b0;
            end
            begin
                exp_t e;
                bit got;
                for (int i = 0; i < vals.size(); i++) begin
                    got = 1'b0;
                    for (int k = 0; k < 40; k++) begin
                        @(negedge clk);
                        if (bus.done) begin got = 1'b1; break; end
                    end
                    if (!got || exp_q.size() == 0) begin
                        total++; bad++; $display("FAIL sweep_%0d got=no_result exp=result", vals[i]);
                    end else begin
                        e = exp_q.pop_front();
                        total++; if (bus.bcd !== e.bcd || bus.ovf !== e.ovf) begin
                            bad++; $display("FAIL sweep_%0d got=%h/%b exp=%h/%b", vals[i], bus.bcd, bus.ovf, e.bcd, e.ovf);
                        end
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_ranges();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin2bcd_4d.md
Name: bin2bcd_4d

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display driver.
- Accepts an unsigned binary value through a valid/ready handshake and converts it to four packed BCD digits using shift-and-add-3 (double-dabble), one bit per clock.
- Presents the result on a held 16-bit register that connects straight to the display's 16-bit data input.
- Values above 9999 saturate to 9999 and raise an overflow flag.

Parameters:
BIN_W, 14, width of the binary input; legal range 4..16 (14 bits covers 0..16383).

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
bin  input  BIN_W  unsigned binary value to convert; sampled only on the accept edge
in_valid  input  1  upstream request: bin is valid
in_ready  output  1  converter idle and able to accept
bcd  output  16  result digits, {thousands, hundreds, tens, ones}, 4 bits each; held between conversions
done  output  1  one-cycle pulse: bcd has just been updated
ovf  output  1  the last completed conversion saturated (bin > 9999)

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n = 0: state = IDLE, bcd = 16'h0000, done = 0, ovf = 0, in_ready = 1, internal shift/scratch/counter registers cleared.
- States: IDLE, SHIFT, DONE.
  - in_ready = 1 only in IDLE.
  - done = 1 only in DONE.
- IDLE:
  - An edge with in_valid = 1 is the accept edge (E0).
  - At E0: bin is copied into a BIN_W-bit shift register and the 16-bit scratch register is cleared.
  - Also at E0: the overflow-pending bit is set to (bin > 9999), bit counter = 0, next state = SHIFT.
  - With in_valid = 0: remain in IDLE; bcd and ovf hold.
- SHIFT, on each edge:
  - First, every scratch nibble >= 5 gets +3, combinationally, all four nibbles in parallel.
  - Then {scratch, shift} shifts left by 1, MSB of shift entering scratch bit 0.
  - Counter increments.
  - The shift performed when counter = BIN_W-1 is the last one (edge E_BIN_W). On that edge:
    - bcd <= 16'h9999 if overflow-pending, else the post-shift scratch value.
    - ovf <= overflow-pending.
    - next state = DONE.
  - Scratch bits shifted out above bit 15 are discarded; only possible when bin > 9999, which is already saturated.
- DONE:
  - done = 1 for exactly one cycle.
  - Next edge (E_BIN_W+1) returns to IDLE.
  - in_ready rises after E_BIN_W+1.
- Latency and throughput:
  - bcd/done/ovf update BIN_W edges after the accept edge (14 for the default).
  - Minimum spacing between accept edges is BIN_W+2 edges.
- Output stability:
  - bcd and ovf change only on the final-shift edge; they hold their previous values throughout SHIFT.
  - The display therefore never shows partial results.
- Handshake boundaries:
  - in_valid while in_ready = 0 is ignored, not queued.
  - A held in_valid is accepted again on the first IDLE edge, with the then-current bin.
  - Changes to bin after E0 have no effect on the running conversion.
- Ranges:
  - bin = 0 gives 16'h0000.
  - bin = 9999 gives 16'h9999 with ovf = 0.
  - Any bin >= 10000 (possible only when BIN_W >= 14) gives 16'h9999 with ovf = 1.
  - ovf clears on the next non-saturating conversion.
- Reset mid-operation:
  - The conversion is aborted immediately and no done pulse is produced.
  - bcd returns to 0000.
  - After release the block is in IDLE and ready.

Test Plan:
1. Hold rst_n = 0 for 3 cycles, then release -> bcd = 16'h0000, ovf = 0, done = 0, in_ready = 1; no activity with in_valid = 0.
2. One-cycle in_valid with bin = 1234 (BIN_W = 14) -> in_ready low for 15 cycles; done high in exactly one cycle, 14 edges after accept; bcd = 16'h1234, ovf = 0; bcd keeps its old value until then.
3. Conversions of 9999, 10000, 16383, 0 in turn -> bcd/ovf = 16'h9999/0, 16'h9999/1, 16'h9999/1, 16'h0000/0.
4. in_valid held high with bin = 42, bin switched to 7 three cycles after accept -> first result 16'h0042, then bin = 7 accepted on the IDLE edge, second result 16'h0007; accept edges 16 cycles apart; bcd = 16'h0042 throughout the second conversion.
5. Accept bin = 5678, assert rst_n low after the 5th shift edge -> bcd = 0000 and in_ready = 1 immediately; no done pulse. Then convert 321 -> 16'h0321.
6. Sweep bin over 0..16383 back to back and compare against a reference model -> every result matches, with ovf set exactly for bin >= 10000.
